// File: rtl/ip_im2colconv_strip_gen_if.sv
// Memory-side bus of the im2col strip convolver: the fmap read port and the result write port.
// The master side belongs to the convolver; the slave side belongs to the BRAMs.
interface ip_im2colconv_strip_gen_if #(
    parameter int DATA_W = 9,
    parameter int ACC_W  = 23,
    parameter int ADDR_W = 16
);
    logic              fmap_rd_en;
    logic [ADDR_W-1:0] fmap_addr;
    logic [DATA_W-1:0] fmap_data;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [ACC_W-1:0]  out_data;

    modport master (
        output fmap_rd_en, fmap_addr, out_we, out_addr, out_data,
        input  fmap_data
    );
    modport slave (
        input  fmap_rd_en, fmap_addr, out_we, out_addr, out_data,
        output fmap_data
    );
endinterface

// File: rtl/ip_im2colconv_strip_gen.sv
// Strip convolver: slides a KxK kernel over an IMG_W x STRIP_H strip, fetching each patch
// im2col-style through a fixed-latency read port and accumulating it with one MAC.
module ip_im2colconv_strip_gen #(
    parameter int DATA_W  = 9,
    parameter int K       = 3,
    parameter int IMG_W   = 224,
    parameter int STRIP_H = 30,
    parameter int STRIDE  = 1,
    parameter int RD_LAT  = 2,
    parameter int ACC_W   = 23,
    parameter int ADDR_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_kernel_read_complete,
    input  logic                  i_relu_en,
    input  logic [K*K*DATA_W-1:0] i_kernel_flat,
    output logic                  o_busy,
    output logic                  o_done,
    ip_im2colconv_strip_gen_if.master bus
);
    localparam int NTAP = K*K;
    localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int KXW  = (K > 1) ? $clog2(K) : 1;
    localparam int WW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int CW   = $clog2(IMG_W + STRIDE + 1);
    localparam int RW   = $clog2(STRIP_H + STRIDE + 1);

    localparam logic [TW-1:0]     TAP_LAST  = TW'(NTAP - 1);
    localparam logic [KXW-1:0]    KX_LAST   = KXW'(K - 1);
    localparam logic [WW-1:0]     WAIT_LOAD = WW'(RD_LAT - 1);
    localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - K);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(STRIP_H - K);
    localparam logic [CW-1:0]     COL_STEP  = CW'(STRIDE);
    localparam logic [RW-1:0]     ROW_STEP  = RW'(STRIDE);
    localparam logic [ADDR_W-1:0] TAP_WRAP  = ADDR_W'(IMG_W - K + 1);
    localparam logic [ADDR_W-1:0] ORG_STEP  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(STRIDE * IMG_W);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_kern [NTAP];
    logic                     r_relu;
    logic [RW-1:0]            r_row;
    logic [CW-1:0]            r_col;
    logic [ADDR_W-1:0]        r_line_base;
    logic [ADDR_W-1:0]        r_org;
    logic [TW-1:0]            r_tap;
    logic [KXW-1:0]           r_kx;
    logic [WW-1:0]            r_wcnt;
    logic [RD_LAT-1:0]        r_vld;
    logic [TW-1:0]            r_tapq [RD_LAT];
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_rd_en;
    logic [ADDR_W-1:0]        r_fmap_addr;
    logic                     r_out_we;
    logic [ADDR_W-1:0]        r_out_addr;
    logic [ACC_W-1:0]         r_out_data;
    logic                     r_busy;
    logic                     r_done;

    logic signed [DATA_W-1:0]   w_ktap;
    logic signed [DATA_W-1:0]   w_pix;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_acc_nx;
    logic [CW-1:0]              w_col_nx;
    logic [RW-1:0]              w_row_nx;
    logic [ADDR_W-1:0]          w_line_nx;
    logic                       w_start_ok;

    // Tap index travels with the read so the right kernel weight meets the returning pixel.
    assign w_ktap     = r_kern[r_tapq[RD_LAT-1]];
    assign w_pix      = $signed(bus.fmap_data);
    assign w_prod     = (2*DATA_W)'(w_pix) * (2*DATA_W)'(w_ktap);
    assign w_acc_nx   = r_acc + ACC_W'(w_prod);
    assign w_col_nx   = r_col + COL_STEP;
    assign w_row_nx   = r_row + ROW_STEP;
    assign w_line_nx  = r_line_base + LINE_STEP;
    assign w_start_ok = i_start && i_kernel_read_complete &&
                        (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < NTAP; i++) r_kern[i] <= '0;
            r_relu      <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_line_base <= '0;
            r_org       <= '0;
            r_tap       <= '0;
            r_kx        <= '0;
            r_wcnt      <= '0;
            r_vld       <= '0;
            for (int i = 0; i < RD_LAT; i++) r_tapq[i] <= '0;
            r_acc       <= '0;
            r_rd_en     <= 1'b0;
            r_fmap_addr <= '0;
            r_out_we    <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vld[0]  <= r_rd_en;
            r_tapq[0] <= r_tap;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_tapq[i] <= r_tapq[i-1];
            end

            // No read of the current patch can have returned during its first ISSUE cycle.
            if (r_state == S_ISSUE && r_tap == '0)
                r_acc <= '0;
            else if (r_vld[RD_LAT-1])
                r_acc <= w_acc_nx;

            r_out_we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        for (int i = 0; i < NTAP; i++)
                            r_kern[i] <= $signed(i_kernel_flat[i*DATA_W +: DATA_W]);
                        r_relu      <= i_relu_en;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_line_base <= '0;
                        r_org       <= '0;
                        r_tap       <= '0;
                        r_kx        <= '0;
                        r_fmap_addr <= '0;
                        r_out_addr  <= '0;
                        r_rd_en     <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_tap == TAP_LAST) begin
                        r_rd_en <= 1'b0;
                        r_wcnt  <= WAIT_LOAD;
                        r_state <= S_WAIT;
                    end else begin
                        r_tap <= r_tap + TW'(1);
                        if (r_kx == KX_LAST) begin
                            r_kx        <= '0;
                            r_fmap_addr <= r_fmap_addr + TAP_WRAP;
                        end else begin
                            r_kx        <= r_kx + KXW'(1);
                            r_fmap_addr <= r_fmap_addr + ADDR_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    // Final product lands this cycle, so the result uses the next accumulator value.
                    if (r_wcnt == '0) begin
                        r_out_we   <= 1'b1;
                        r_out_data <= (r_relu && w_acc_nx[ACC_W-1]) ? '0 : w_acc_nx;
                        r_state    <= S_WRITE;
                    end else begin
                        r_wcnt <= r_wcnt - WW'(1);
                    end
                end
                S_WRITE: begin
                    r_tap <= '0;
                    r_kx  <= '0;
                    if (w_col_nx > COL_LAST) begin
                        if (w_row_nx > ROW_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row       <= w_row_nx;
                            r_col       <= '0;
                            r_line_base <= w_line_nx;
                            r_org       <= w_line_nx;
                            r_fmap_addr <= w_line_nx;
                            r_out_addr  <= r_out_addr + ADDR_W'(1);
                            r_rd_en     <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end else begin
                        r_col       <= w_col_nx;
                        r_org       <= r_org + ORG_STEP;
                        r_fmap_addr <= r_org + ORG_STEP;
                        r_out_addr  <= r_out_addr + ADDR_W'(1);
                        r_rd_en     <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.fmap_rd_en = r_rd_en;
    assign bus.fmap_addr  = r_fmap_addr;
    assign bus.out_we     = r_out_we;
    assign bus.out_addr   = r_out_addr;
    assign bus.out_data   = r_out_data;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
endmodule
